// File: rtl/fafs_pkg.sv
// Shared constants and FSM state type for the bit-serial add/subtract engine.
package fafs_pkg;
  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} fafs_state_t;
endpackage

// File: rtl/fafs_bit_cell.sv
// One-bit full-adder / full-subtractor; mode picks carry or borrow generation.
module fafs_bit_cell
  import fafs_pkg::*;
(
  input  logic x,
  input  logic y,
  input  logic z,
  input  logic mode,
  output logic sd,
  output logic cb
);
  assign sd = x ^ y ^ z;
  assign cb = (mode == MODE_SUB) ? ((~x & y) | (~x & z) | (y & z))
                                 : ((x & y) | (y & z) | (x & z));
endmodule

// File: rtl/fafs_serial_engine.sv
// Bit-serial add/subtract engine, LSB first, one bit per clock.
// Define FAFS_OVERFLOW_FLAG_EN to add the signed-overflow output out_ovf.
module fafs_serial_engine
  import fafs_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_cb
`ifdef FAFS_OVERFLOW_FLAG_EN
  ,
  output logic             out_ovf
`endif
);
  localparam int CNT_W = $clog2(WIDTH);

  fafs_state_t      state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, res_sh;
  logic [CNT_W-1:0] cnt;
  logic             mode_q, cb_reg;
  logic             sd, cb_nxt, last;

  assign last = (cnt == CNT_W'(WIDTH - 1));

  fafs_bit_cell u_cell (
    .x    (a_sh[0]),
    .y    (b_sh[0]),
    .z    (cb_reg),
    .mode (mode_q),
    .sd   (sd),
    .cb   (cb_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = ST_RUN;
      end
      ST_RUN:  if (last) state_nxt = ST_DONE;
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Result fills from the MSB end so after WIDTH shifts bit 0 lands at bit 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      cnt    <= '0;
      mode_q <= MODE_ADD;
      cb_reg <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (in_valid) begin
          a_sh   <= in_a;
          b_sh   <= in_b;
          mode_q <= in_mode;
          cb_reg <= 1'b0;
          cnt    <= '0;
        end
        ST_RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= {sd, res_sh[WIDTH-1:1]};
          cb_reg <= cb_nxt;
          cnt    <= cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign out_result = res_sh;
  assign out_cb     = cb_reg;

`ifdef FAFS_OVERFLOW_FLAG_EN
  logic ovf_reg;
  // Carry/borrow into the MSB step is cb_reg, out of it is cb_nxt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      ovf_reg <= 1'b0;
    else if (state == ST_RUN && last) ovf_reg <= cb_reg ^ cb_nxt;
  end
  assign out_ovf = ovf_reg;
`endif
endmodule

// File: tb/tb_fafs_serial_engine.sv
// Directed and randomised self-check of fafs_serial_engine at WIDTH=8.
module tb_fafs_serial_engine;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_a = '0;
  logic [WIDTH-1:0] in_b = '0;
  logic             in_mode = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_result;
  logic             out_cb;
`ifdef FAFS_OVERFLOW_FLAG_EN
  logic             out_ovf;
`endif

  int n_chk = 0;
  int n_err = 0;

  fafs_serial_engine #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_mode    (in_mode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_cb     (out_cb)
`ifdef FAFS_OVERFLOW_FLAG_EN
    ,
    .out_ovf    (out_ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Runs one operation; all timing is #1 after a rising edge.
  task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic m, input logic [7:0] er, input logic ecb,
                       input logic eovf, input int stall, input bit noise);
    int lat;
    logic [7:0] hold_r;
    logic       hold_cb;
    lat = 0;
    while (!in_ready && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    chk({tag, ".ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_a = a; in_b = b; in_mode = m;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      if (noise) begin
        in_valid = 1'($urandom); in_a = 8'($urandom); in_b = 8'($urandom);
        in_mode = 1'($urandom);
      end
      chk({tag, ".busy"}, 32'(in_ready), 32'd0);
      @(posedge clk); #1; lat++;
    end
    in_valid = 1'b0;
    chk({tag, ".lat"}, 32'(lat), 32'(WIDTH + 1));
    hold_r  = out_result;
    hold_cb = out_cb;
    for (int i = 0; i < stall; i++) begin
      if (noise) begin
        in_valid = 1'($urandom); in_a = 8'($urandom); in_mode = 1'($urandom);
      end
      @(posedge clk); #1;
      chk({tag, ".hold_v"},  32'(out_valid), 32'd1);
      chk({tag, ".hold_r"},  32'(out_result), 32'(hold_r));
      chk({tag, ".hold_cb"}, 32'(out_cb), 32'(hold_cb));
      chk({tag, ".hold_rdy"}, 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".res"},   32'(out_result), 32'(er));
    chk({tag, ".cb"},    32'(out_cb), 32'(ecb));
`ifdef FAFS_OVERFLOW_FLAG_EN
    chk({tag, ".ovf"},   32'(out_ovf), 32'(eovf));
`else
    if (eovf === 1'bx) n_err++;
`endif
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, ".drop"},  32'(out_valid), 32'd0);
    chk({tag, ".idle"},  32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [7:0] a, b, r;
    logic       m, cb, ovf;
    logic [8:0] s;

    repeat (2) @(posedge clk);
    #1;
    chk("rst.ready", 32'(in_ready), 32'd1);
    chk("rst.valid", 32'(out_valid), 32'd0);
    chk("rst.res",   32'(out_result), 32'd0);
    chk("rst.cb",    32'(out_cb), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op("add5a3c", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1, 0, 1'b0);
    do_op("addff01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0);
    do_op("sub1001", 8'h10, 8'h01, 1'b1, 8'h0F, 1'b0, 1'b0, 0, 1'b0);
    do_op("sub0001", 8'h00, 8'h01, 1'b1, 8'hFF, 1'b1, 1'b0, 0, 1'b0);
    do_op("sub8001", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b0, 1'b1, 0, 1'b0);
    do_op("bp",      8'h33, 8'h44, 1'b0, 8'h77, 1'b0, 1'b0, 5, 1'b1);

    // Abort mid-RUN with an asynchronous reset.
    in_valid = 1'b1; in_a = 8'hAA; in_b = 8'hCC; in_mode = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort.valid", 32'(out_valid), 32'd0);
    chk("abort.ready", 32'(in_ready), 32'd1);
    chk("abort.res",   32'(out_result), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("abort.ready2", 32'(in_ready), 32'd1);
    do_op("post", 8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0, 0, 1'b0);

    for (int k = 0; k < 1000; k++) begin
      a = 8'($urandom); b = 8'($urandom); m = 1'($urandom);
      s = m ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
      r = s[7:0];
      cb = m ? (a < b) : s[8];
      ovf = m ? ((a[7] != b[7]) && (r[7] != a[7])) : ((a[7] == b[7]) && (r[7] != a[7]));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      do_op("rnd", a, b, m, r, cb, ovf, $urandom_range(0, 3), 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
